packet_injector: RTL and testbench

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/noc_pkg.sv | 20 ++
 rtl/flit_down_counter.sv | 39 +++
 rtl/packet_injector.sv | 150 +++++++++++++++
 tb/tb_packet_injector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, length width and injector FSM encoding.
package noc_pkg;

    localparam int unsigned LEN_W = 12;

    localparam logic [2:0] FLIT_IDLE   = 3'b000;
    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_REQ   = 6'b000010,
        ST_HEAD  = 6'b000100,
        ST_BODY  = 6'b001000,
        ST_TAIL  = 6'b010000,
        ST_ABORT = 6'b100000
    } state_e;

endpackage

// File: rtl/flit_down_counter.sv
// Remaining-flit down counter; the decrement saturates at 1 so the count never wraps.
module flit_down_counter
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic             is_one_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q > LEN_W'(1))) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    // is_one is registered from the next count so it is valid in the cycle the count is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            is_one_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            is_one_q <= (count_d == LEN_W'(1));
        end
    end

    assign is_one_o = is_one_q;

endmodule

// File: rtl/packet_injector.sv
// Packet injector: takes a length descriptor, arbitrates for the port and emits
// header/body/tail flits, aborting the packet if the grant is lost mid-packet.
module packet_injector
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MIN_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [11:0]       pkt_length,
    output logic              pkt_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              req,
    input  logic              grant,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_valid,
    output logic              done,
    output logic              abort
);

    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             done_q;
    logic             done_d;
    logic [LEN_W-1:0] len_clamped;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_one;

    assign len_clamped = (pkt_length < MIN_LEN_L) ? MIN_LEN_L : pkt_length;

    flit_down_counter u_remaining (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .load_val_i (len_clamped - LEN_W'(1)),
        .dec_i      (cnt_dec),
        .is_one_o   (cnt_is_one)
    );

    // Next-state and per-state handshake decode; a flit moves only while grant is high.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        done_d     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        pkt_ready  = 1'b0;
        req        = 1'b0;
        flit_id    = FLIT_IDLE;
        length     = '0;
        flit_data  = '0;
        flit_valid = 1'b0;
        data_ready = 1'b0;
        abort      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    len_d    = len_clamped;
                    cnt_load = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                req       = 1'b1;
                flit_id   = FLIT_HEADER;
                length    = len_q;
                flit_data = DATA_W'(len_q);
                if (grant) begin
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                req       = 1'b1;
                flit_id   = FLIT_HEADER;
                length    = len_q;
                flit_data = DATA_W'(len_q);
                if (!grant) begin
                    state_d = ST_ABORT;
                end else begin
                    flit_valid = 1'b1;
                    cnt_dec    = 1'b1;
                    state_d    = cnt_is_one ? ST_TAIL : ST_BODY;
                end
            end
            ST_BODY: begin
                req        = 1'b1;
                flit_id    = FLIT_BODY;
                flit_data  = data_in;
                data_ready = grant;
                if (!grant) begin
                    state_d = ST_ABORT;
                end else if (data_valid) begin
                    flit_valid = 1'b1;
                    cnt_dec    = 1'b1;
                    if (cnt_is_one) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                req        = 1'b1;
                flit_id    = FLIT_TAIL;
                flit_data  = data_in;
                data_ready = grant;
                if (!grant) begin
                    state_d = ST_ABORT;
                end else if (data_valid) begin
                    flit_valid = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_ABORT: begin
                abort   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: normal packets, clamping, grant wait,
// data stalls, grant-loss abort and mid-packet reset.
module tb_packet_injector;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              pkt_valid;
    logic [11:0]       pkt_length;
    logic              pkt_ready;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              req;
    logic              grant;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic [DATA_W-1:0] flit_data;
    logic              flit_valid;
    logic              done;
    logic              abort;

    int n_total;
    int n_bad;

    packet_injector #(.DATA_W(DATA_W), .MIN_LEN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .pkt_length (pkt_length),
        .pkt_ready  (pkt_ready),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .req        (req),
        .grant      (grant),
        .flit_id    (flit_id),
        .length     (length),
        .flit_data  (flit_data),
        .flit_valid (flit_valid),
        .done       (done),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    // One full packet with optional grant wait and an optional data stall before flit stall_at.
    task automatic run_pkt(input int len_in, input int len_exp, input int gnt_wait,
                           input int stall_at, input int stall_n);
        int         nflit;
        logic [2:0] exp_id;
        nflit = 0;
        go();
        pkt_valid  = 1'b1;
        pkt_length = 12'(len_in);
        grant      = (gnt_wait == 0);
        data_valid = 1'b0;
        probe();
        check("idle_ready", 32'(pkt_ready), 32'd1);
        check("idle_req", 32'(req), 32'd0);
        for (int w = 0; w <= gnt_wait; w++) begin
            go();
            pkt_valid = 1'b0;
            grant     = (w == gnt_wait);
            probe();
            check("req_req", 32'(req), 32'd1);
            check("req_id", 32'(flit_id), 32'd1);
            check("req_len", 32'(length), 32'(len_exp));
            check("req_data", flit_data, 32'(len_exp));
            check("req_fv", 32'(flit_valid), 32'd0);
        end
        go();
        probe();
        check("hdr_fv", 32'(flit_valid), 32'd1);
        check("hdr_id", 32'(flit_id), 32'd1);
        check("hdr_data", flit_data, 32'(len_exp));
        if (flit_valid) nflit++;
        for (int k = 1; k < len_exp; k++) begin
            exp_id = (k == len_exp - 1) ? 3'b100 : 3'b010;
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    go();
                    data_valid = 1'b0;
                    probe();
                    check("stall_fv", 32'(flit_valid), 32'd0);
                    check("stall_id", 32'(flit_id), 32'(exp_id));
                    check("stall_req", 32'(req), 32'd1);
                end
            end
            go();
            data_valid = 1'b1;
            data_in    = 32'hD000_0000 + 32'(k);
            probe();
            check("pl_fv", 32'(flit_valid), 32'd1);
            check("pl_id", 32'(flit_id), 32'(exp_id));
            check("pl_data", flit_data, 32'hD000_0000 + 32'(k));
            check("pl_rdy", 32'(data_ready), 32'd1);
            check("pl_req", 32'(req), 32'd1);
            check("pl_done", 32'(done), 32'd0);
            if (flit_valid) nflit++;
        end
        go();
        data_valid = 1'b0;
        probe();
        check("end_done", 32'(done), 32'd1);
        check("end_req", 32'(req), 32'd0);
        check("end_id", 32'(flit_id), 32'd0);
        check("end_fv", 32'(flit_valid), 32'd0);
        check("flit_count", 32'(nflit), 32'(len_exp));
        go();
        probe();
        check("post_done", 32'(done), 32'd0);
        check("post_req", 32'(req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b0;
        pkt_valid  = 1'b0;
        pkt_length = '0;
        data_in    = '0;
        data_valid = 1'b0;
        grant      = 1'b0;
        #3;
        check("rst_req", 32'(req), 32'd0);
        check("rst_id", 32'(flit_id), 32'd0);
        check("rst_len", 32'(length), 32'd0);
        check("rst_data", flit_data, 32'd0);
        check("rst_fv", 32'(flit_valid), 32'd0);
        check("rst_rdy", 32'(data_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        #9 rst = 1'b1;

        run_pkt(4, 4, 0, 0, 0);
        run_pkt(0, 2, 0, 0, 0);
        run_pkt(3, 3, 5, 0, 0);
        run_pkt(5, 5, 0, 2, 3);

        // Grant lost after the second body flit of a 6-flit packet.
        go();
        pkt_valid  = 1'b1;
        pkt_length = 12'd6;
        grant      = 1'b1;
        data_valid = 1'b0;
        probe();
        check("ab_accept", 32'(pkt_ready), 32'd1);
        go();
        pkt_valid = 1'b0;
        probe();
        check("ab_reqst", 32'(req), 32'd1);
        go();
        probe();
        check("ab_hdr", 32'(flit_valid), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            go();
            data_valid = 1'b1;
            data_in    = 32'hB000_0000 + 32'(k);
            probe();
            check("ab_body_fv", 32'(flit_valid), 32'd1);
            check("ab_body_id", 32'(flit_id), 32'd2);
        end
        go();
        grant = 1'b0;
        probe();
        check("ab_drop_fv", 32'(flit_valid), 32'd0);
        check("ab_drop_rdy", 32'(data_ready), 32'd0);
        check("ab_drop_abort", 32'(abort), 32'd0);
        go();
        probe();
        check("ab_pulse", 32'(abort), 32'd1);
        check("ab_req", 32'(req), 32'd0);
        check("ab_fv", 32'(flit_valid), 32'd0);
        check("ab_rdy", 32'(data_ready), 32'd0);
        check("ab_id", 32'(flit_id), 32'd0);
        go();
        data_valid = 1'b0;
        probe();
        check("ab_clear", 32'(abort), 32'd0);
        check("ab_idle_ready", 32'(pkt_ready), 32'd1);
        check("ab_no_done", 32'(done), 32'd0);

        // Reset asserted while the packet is in its body.
        go();
        pkt_valid  = 1'b1;
        pkt_length = 12'd5;
        grant      = 1'b1;
        probe();
        go();
        pkt_valid = 1'b0;
        go();
        go();
        data_valid = 1'b1;
        data_in    = 32'hCAFE_0001;
        probe();
        check("rs_body_fv", 32'(flit_valid), 32'd1);
        go();
        #1 rst = 1'b0;
        #1;
        check("rs_req", 32'(req), 32'd0);
        check("rs_fv", 32'(flit_valid), 32'd0);
        check("rs_id", 32'(flit_id), 32'd0);
        check("rs_len", 32'(length), 32'd0);
        check("rs_data", flit_data, 32'd0);
        check("rs_rdy", 32'(data_ready), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        check("rs_abort", 32'(abort), 32'd0);
        data_valid = 1'b0;
        #2 rst = 1'b1;

        run_pkt(3, 3, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
